// File: rtl/interrupt_arbiter_pkg.sv
// rtl/interrupt_arbiter_pkg.sv - shared source, vector and state codes for the interrupt arbiter
package interrupt_arbiter_pkg;

    typedef enum logic {
        INTidle    = 1'b0,
        INTservice = 1'b1
    } intState_t;

    localparam logic [1:0] SRC_IRQ = 2'd0;
    localparam logic [1:0] SRC_NMI = 2'd1;
    localparam logic [1:0] SRC_RES = 2'd2;
    localparam logic [1:0] SRC_BRK = 2'd3;

    localparam logic [7:0] VEC_NMI = 8'hFA;
    localparam logic [7:0] VEC_RES = 8'hFC;
    localparam logic [7:0] VEC_IRQ = 8'hFE;

    // BRK shares the IRQ vector; only the pushed B flag tells them apart.
    function automatic logic [7:0] vecFor(input logic [1:0] src);
        case (src)
            SRC_NMI: vecFor = VEC_NMI;
            SRC_RES: vecFor = VEC_RES;
            default: vecFor = VEC_IRQ;
        endcase
    endfunction

endpackage

// File: rtl/interrupt_arbiter_pin_sync.sv
// rtl/interrupt_arbiter_pin_sync.sv - flop-chain synchronizer for an active-low async pin
module interrupt_arbiter_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic phi1,
    input  logic rstN,
    input  logic pin,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Resets to 1 so a pin that is already low after reset still shows a fresh edge.
    always_ff @(posedge phi1) begin
        if (!rstN) begin
            chain <= '1;
        end else begin
            chain[0] <= pin;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/interrupt_arbiter.sv
// rtl/interrupt_arbiter.sv - RES/NMI/IRQ/BRK arbitration, vector select and NMI hijack for the 6502 core
module interrupt_arbiter
    import interrupt_arbiter_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int SERVICE_TIMEOUT = 15
) (
    input  logic       phi1,
    input  logic       rstN,
    input  logic       haltAll,
    input  logic       nmiN,
    input  logic       irqN,
    input  logic       iFlag,
    input  logic       fetchSlot,
    input  logic       brkOp,
    input  logic       vecFetch,
    input  logic       intHandled,
    output logic       brkNow,
    output logic [7:0] vecLo,
    output logic       bFlag,
    output logic [1:0] intSrc,
    output logic       nmiPend,
    output logic       inService,
    output logic       errTimeout
);

    localparam int CW = $clog2(SERVICE_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SERVICE_TIMEOUT);

    logic          nmiS, irqS, nmiPrev, nmiEdge, irqReq;
    logic          nmiLatch, latchNext;
    intState_t     state, stateNext;
    logic [1:0]    srcNext;
    logic [7:0]    vecNext;
    logic          bNext, lockNext, errNext, vecLock;
    logic [CW-1:0] cnt, cntNext;

    interrupt_arbiter_pin_sync #(.STAGES(SYNC_STAGES)) uNmiSync (
        .phi1(phi1), .rstN(rstN), .pin(nmiN), .q(nmiS)
    );

    interrupt_arbiter_pin_sync #(.STAGES(SYNC_STAGES)) uIrqSync (
        .phi1(phi1), .rstN(rstN), .pin(irqN), .q(irqS)
    );

    assign nmiEdge   = nmiPrev & ~nmiS;
    assign irqReq    = ~irqS & ~iFlag;
    assign nmiPend   = nmiLatch;
    assign inService = (state == INTservice);

    always_comb begin
        stateNext = state;
        srcNext   = intSrc;
        vecNext   = vecLo;
        bNext     = bFlag;
        cntNext   = cnt;
        lockNext  = vecLock;
        errNext   = 1'b0;
        latchNext = nmiLatch | nmiEdge;
        brkNow    = 1'b0;
        if (!haltAll) begin
            case (state)
                INTidle: begin
                    brkNow = fetchSlot & (nmiLatch | irqReq);
                    if (brkNow) begin
                        stateNext = INTservice;
                        srcNext   = nmiLatch ? SRC_NMI : SRC_IRQ;
                        vecNext   = vecFor(srcNext);
                        bNext     = 1'b0;
                        cntNext   = '0;
                        lockNext  = 1'b0;
                    end else if (fetchSlot && brkOp) begin
                        stateNext = INTservice;
                        srcNext   = SRC_BRK;
                        vecNext   = VEC_IRQ;
                        bNext     = 1'b1;
                        cntNext   = '0;
                        lockNext  = 1'b0;
                    end
                end
                INTservice: begin
                    if (intHandled) begin
                        stateNext = INTidle;
                        cntNext   = '0;
                        lockNext  = 1'b0;
                        // A fresh edge arriving as the NMI retires is a new request.
                        if (intSrc == SRC_NMI && !nmiEdge) begin
                            latchNext = 1'b0;
                        end
                    end else if (cnt == CNT_MAX) begin
                        errNext   = 1'b1;
                        stateNext = INTidle;
                        cntNext   = '0;
                        lockNext  = 1'b0;
                    end else begin
                        cntNext = cnt + CW'(1);
                        if (vecFetch) begin
                            lockNext = 1'b1;
                        end else if (!vecLock && nmiLatch &&
                                     (intSrc == SRC_IRQ || intSrc == SRC_BRK)) begin
                            srcNext = SRC_NMI;
                            vecNext = VEC_NMI;
                        end
                    end
                end
                default: stateNext = INTidle;
            endcase
        end
    end

    always_ff @(posedge phi1) begin
        if (!rstN) begin
            state      <= INTservice;
            intSrc     <= SRC_RES;
            vecLo      <= VEC_RES;
            bFlag      <= 1'b0;
            nmiLatch   <= 1'b0;
            nmiPrev    <= 1'b1;
            cnt        <= '0;
            vecLock    <= 1'b0;
            errTimeout <= 1'b0;
        end else begin
            state      <= stateNext;
            intSrc     <= srcNext;
            vecLo      <= vecNext;
            bFlag      <= bNext;
            nmiLatch   <= latchNext;
            nmiPrev    <= nmiS;
            cnt        <= cntNext;
            vecLock    <= lockNext;
            errTimeout <= errNext;
        end
    end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// tb/tb_interrupt_arbiter.sv - scoreboard bench for interrupt_arbiter
module tb_interrupt_arbiter;

    logic       phi1 = 1'b0;
    logic       rstN = 1'b0, haltAll = 1'b0, nmiN = 1'b1, irqN = 1'b1, iFlag = 1'b1;
    logic       fetchSlot = 1'b0, brkOp = 1'b0, vecFetch = 1'b0, intHandled = 1'b0;
    logic       brkNow, bFlag, nmiPend, inService, errTimeout;
    logic [7:0] vecLo;
    logic [1:0] intSrc;

    interrupt_arbiter #(.SYNC_STAGES(2), .SERVICE_TIMEOUT(15)) dut (
        .phi1(phi1), .rstN(rstN), .haltAll(haltAll), .nmiN(nmiN), .irqN(irqN),
        .iFlag(iFlag), .fetchSlot(fetchSlot), .brkOp(brkOp), .vecFetch(vecFetch),
        .intHandled(intHandled), .brkNow(brkNow), .vecLo(vecLo), .bFlag(bFlag),
        .intSrc(intSrc), .nmiPend(nmiPend), .inService(inService), .errTimeout(errTimeout)
    );

    always #5 phi1 = ~phi1;

    int cyc = 0;
    always @(posedge phi1) cyc <= cyc + 1;

    localparam int S_BRKNOW = 0, S_VEC = 1, S_BFLAG = 2, S_SRC = 3, S_PEND = 4, S_SERV = 5, S_ERR = 6;

    typedef struct {
        int         stamp;
        int         sig;
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFails  = 0;

    function automatic logic [7:0] probe(input int sig);
        case (sig)
            S_BRKNOW: probe = {7'b0, brkNow};
            S_VEC:    probe = vecLo;
            S_BFLAG:  probe = {7'b0, bFlag};
            S_SRC:    probe = {6'b0, intSrc};
            S_PEND:   probe = {7'b0, nmiPend};
            S_SERV:   probe = {7'b0, inService};
            default:  probe = {7'b0, errTimeout};
        endcase
    endfunction

    task automatic expectSig(input int sig, input logic [7:0] val, input string name);
        exp_t e;
        e.stamp = cyc;
        e.sig   = sig;
        e.val   = val;
        e.name  = name;
        expQ.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge phi1);
            #1;
        end
    endtask

    always @(negedge phi1) begin
        while (expQ.size() > 0 && expQ[0].stamp <= cyc) begin
            exp_t e;
            e = expQ.pop_front();
            nChecks = nChecks + 1;
            if (e.stamp != cyc) begin
                nFails = nFails + 1;
                $display("FAIL %s: expectation from cycle %0d not sampled until cycle %0d", e.name, e.stamp, cyc);
            end else if (probe(e.sig) !== e.val) begin
                nFails = nFails + 1;
                $display("FAIL %s: got %02h, expected %02h (cycle %0d)", e.name, probe(e.sig), e.val, cyc);
            end
        end
    end

    initial begin
        // Reset
        tick(2);
        rstN = 1'b1;
        expectSig(S_SERV, 8'h01, "reset inService");
        expectSig(S_VEC, 8'hFC, "reset vecLo");
        expectSig(S_SRC, 8'h02, "reset intSrc");
        expectSig(S_BFLAG, 8'h00, "reset bFlag");
        expectSig(S_PEND, 8'h00, "reset nmiPend");
        expectSig(S_ERR, 8'h00, "reset errTimeout");
        expectSig(S_BRKNOW, 8'h00, "reset brkNow");
        intHandled = 1'b1;
        tick();
        intHandled = 1'b0;
        expectSig(S_SERV, 8'h00, "reset retire inService");

        // IRQ mask
        irqN = 1'b0;
        iFlag = 1'b1;
        tick(2);
        fetchSlot = 1'b1;
        expectSig(S_BRKNOW, 8'h00, "irq masked brkNow");
        tick();
        iFlag = 1'b0;
        expectSig(S_BRKNOW, 8'h01, "irq unmasked brkNow");
        tick();
        fetchSlot = 1'b0;
        expectSig(S_SERV, 8'h01, "irq inService");
        expectSig(S_VEC, 8'hFE, "irq vecLo");
        expectSig(S_BFLAG, 8'h00, "irq bFlag");
        expectSig(S_SRC, 8'h00, "irq intSrc");
        intHandled = 1'b1;
        tick();
        intHandled = 1'b0;
        irqN = 1'b1;
        iFlag = 1'b1;
        expectSig(S_SERV, 8'h00, "irq retire inService");

        // NMI latency, service, held-low pin
        nmiN = 1'b0;
        tick();
        expectSig(S_PEND, 8'h00, "nmi pend +1");
        tick();
        expectSig(S_PEND, 8'h00, "nmi pend +2");
        tick();
        expectSig(S_PEND, 8'h01, "nmi pend +3");
        fetchSlot = 1'b1;
        expectSig(S_BRKNOW, 8'h01, "nmi brkNow");
        tick();
        fetchSlot = 1'b0;
        expectSig(S_VEC, 8'hFA, "nmi vecLo");
        expectSig(S_SRC, 8'h01, "nmi intSrc");
        expectSig(S_BFLAG, 8'h00, "nmi bFlag");
        intHandled = 1'b1;
        tick();
        intHandled = 1'b0;
        expectSig(S_PEND, 8'h00, "nmi retire nmiPend");
        expectSig(S_SERV, 8'h00, "nmi retire inService");
        fetchSlot = 1'b1;
        expectSig(S_BRKNOW, 8'h00, "nmi held low brkNow");
        tick();
        fetchSlot = 1'b0;
        expectSig(S_SERV, 8'h00, "nmi held low inService");
        nmiN = 1'b1;
        tick(3);

        // Hijack of BRK before vector lock
        fetchSlot = 1'b1;
        brkOp = 1'b1;
        expectSig(S_BRKNOW, 8'h00, "brk brkNow");
        tick();
        fetchSlot = 1'b0;
        brkOp = 1'b0;
        expectSig(S_BFLAG, 8'h01, "brk bFlag");
        expectSig(S_VEC, 8'hFE, "brk vecLo");
        expectSig(S_SRC, 8'h03, "brk intSrc");
        nmiN = 1'b0;
        tick(3);
        expectSig(S_PEND, 8'h01, "hijack nmiPend");
        expectSig(S_VEC, 8'hFE, "hijack pre vecLo");
        tick();
        expectSig(S_VEC, 8'hFA, "hijack vecLo");
        expectSig(S_SRC, 8'h01, "hijack intSrc");
        expectSig(S_BFLAG, 8'h01, "hijack bFlag");
        vecFetch = 1'b1;
        tick();
        vecFetch = 1'b0;
        intHandled = 1'b1;
        tick();
        intHandled = 1'b0;
        expectSig(S_PEND, 8'h00, "hijack retire nmiPend");
        expectSig(S_SERV, 8'h00, "hijack retire inService");
        nmiN = 1'b1;
        tick(3);

        // NMI after vector lock waits for the next slot
        fetchSlot = 1'b1;
        brkOp = 1'b1;
        tick();
        fetchSlot = 1'b0;
        brkOp = 1'b0;
        vecFetch = 1'b1;
        tick();
        vecFetch = 1'b0;
        nmiN = 1'b0;
        tick(4);
        expectSig(S_VEC, 8'hFE, "locked vecLo");
        expectSig(S_SRC, 8'h03, "locked intSrc");
        expectSig(S_PEND, 8'h01, "locked nmiPend");
        intHandled = 1'b1;
        tick();
        intHandled = 1'b0;
        expectSig(S_PEND, 8'h01, "locked retire nmiPend");
        expectSig(S_SERV, 8'h00, "locked retire inService");
        fetchSlot = 1'b1;
        expectSig(S_BRKNOW, 8'h01, "deferred nmi brkNow");
        tick();
        fetchSlot = 1'b0;
        expectSig(S_VEC, 8'hFA, "deferred nmi vecLo");
        expectSig(S_SRC, 8'h01, "deferred nmi intSrc");
        expectSig(S_BFLAG, 8'h00, "deferred nmi bFlag");
        intHandled = 1'b1;
        tick();
        intHandled = 1'b0;
        expectSig(S_PEND, 8'h00, "deferred retire nmiPend");
        nmiN = 1'b1;
        tick(3);

        // Collisions
        nmiN = 1'b0;
        irqN = 1'b0;
        iFlag = 1'b0;
        tick(3);
        fetchSlot = 1'b1;
        brkOp = 1'b1;
        expectSig(S_BRKNOW, 8'h01, "collide brkNow");
        tick();
        fetchSlot = 1'b0;
        brkOp = 1'b0;
        expectSig(S_SRC, 8'h01, "collide intSrc");
        expectSig(S_VEC, 8'hFA, "collide vecLo");
        expectSig(S_BFLAG, 8'h00, "collide bFlag");
        nmiN = 1'b1;
        irqN = 1'b1;
        iFlag = 1'b1;
        tick(3);
        nmiN = 1'b0;
        tick(2);
        intHandled = 1'b1;
        tick();
        intHandled = 1'b0;
        expectSig(S_PEND, 8'h01, "edge with retire nmiPend");
        expectSig(S_SERV, 8'h00, "edge with retire inService");
        fetchSlot = 1'b1;
        tick();
        fetchSlot = 1'b0;
        intHandled = 1'b1;
        tick();
        intHandled = 1'b0;
        expectSig(S_PEND, 8'h00, "second nmi retire nmiPend");
        nmiN = 1'b1;
        tick(3);

        // Service timeout
        fetchSlot = 1'b1;
        brkOp = 1'b1;
        tick();
        fetchSlot = 1'b0;
        brkOp = 1'b0;
        tick(15);
        expectSig(S_SERV, 8'h01, "pre-timeout inService");
        expectSig(S_ERR, 8'h00, "pre-timeout errTimeout");
        tick();
        expectSig(S_ERR, 8'h01, "timeout errTimeout");
        expectSig(S_SERV, 8'h00, "timeout inService");
        tick();
        expectSig(S_ERR, 8'h00, "timeout pulse end");

        // Halt mid-service
        fetchSlot = 1'b1;
        brkOp = 1'b1;
        tick();
        fetchSlot = 1'b0;
        brkOp = 1'b0;
        tick(5);
        haltAll = 1'b1;
        nmiN = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            expectSig(S_ERR, 8'h00, "halt errTimeout");
        end
        expectSig(S_SERV, 8'h01, "halt inService");
        expectSig(S_PEND, 8'h01, "halt nmiPend");
        expectSig(S_VEC, 8'hFE, "halt vecLo");
        haltAll = 1'b0;
        tick();
        expectSig(S_VEC, 8'hFA, "post-halt hijack vecLo");
        expectSig(S_SRC, 8'h01, "post-halt hijack intSrc");
        intHandled = 1'b1;
        tick();
        intHandled = 1'b0;
        expectSig(S_PEND, 8'h00, "post-halt retire nmiPend");
        expectSig(S_SERV, 8'h00, "post-halt retire inService");
        nmiN = 1'b1;
        tick(3);

        for (int i = 0; i < 50 && expQ.size() > 0; i++) @(posedge phi1);
        if (expQ.size() > 0) begin
            nFails = nFails + 1;
            $display("FAIL scoreboard drain: %0d expectations left, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
